// File: rtl/pipe_register.sv
// Purpose : chain of Stages data registers, each with its own valid bit, handshaked valid/ready on both ends.
// Latency : a word accepted at edge k is presented on out_data after edge k+Stages-1; 1 word/cycle throughput.
// Backpr. : per-stage bubble collapsing; empty stages keep filling under a stalled output, in_ready drops only when full.
//
// Ports:
//   clock, reset_n          - single clock, asynchronous active-low reset (clears valids and data)
//   in_data/in_valid/in_ready    - upstream handshake
//   out_data/out_valid/out_ready - downstream handshake; out_ready reaches in_ready combinationally
//   flush                   - synchronous clear of every valid bit (data untouched, input word discarded)
//   count                   - occupancy; live only when PIPE_REGISTER_COUNT_EN is defined, otherwise tied to 0
//
// Optional build macro: PIPE_REGISTER_COUNT_EN enables the registered occupancy counter.

module pipe_register #(
  parameter int Width  = 32,
  parameter int Stages = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [Width-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [Width-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flush,
  output logic [$clog2(Stages+1)-1:0]   count
);

  localparam int CntW = $clog2(Stages + 1);

  logic [Width-1:0]  d     [Stages];
  logic [Stages-1:0] v;
  logic [Stages-1:0] r;
  logic [Width-1:0]  up_d  [Stages];
  logic [Stages-1:0] up_v;
  logic              ready_chain;

  // A stage may load when it is empty or everything downstream of it can move.
  // Built as a running term inside one block so the chain is a plain
  // combinational cascade rather than a vector feeding back on itself.
  always_comb begin
    ready_chain = out_ready;
    r           = '0;
    for (int i = Stages - 1; i >= 0; i--) begin
      ready_chain = !v[i] | ready_chain;
      r[i]        = ready_chain;
    end
  end

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < Stages; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < Stages; i++) begin
        d[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < Stages; i++) begin
        if (r[i]) begin
          v[i] <= up_v[i];
          // Data is don't-care while invalid, so only capture real words.
          if (up_v[i]) begin
            d[i] <= up_d[i];
          end
        end
      end
    end
  end

  assign in_ready  = r[0];
  assign out_valid = v[Stages-1];
  assign out_data  = d[Stages-1];

`ifdef PIPE_REGISTER_COUNT_EN
  logic [CntW-1:0] cnt;
  logic            in_xfer;
  logic            out_xfer;

  assign in_xfer  = in_valid & r[0];
  assign out_xfer = v[Stages-1] & out_ready;

  // Tracks popcount(v) incrementally: +1 on a lone input transfer,
  // -1 on a lone output transfer, flush overrides both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
`else
  assign count = '0;
`endif

endmodule
